// File: rtl/fpnew_pkg.sv
// -----------------------------------------------------------------------------
// fpnew_pkg
// Shared types and constants for the opgroup scheduler.
//   sched_id_t   : requester index stored per in-flight op
//   SCHED_ID_W   : width of sched_id_t (up to 2**SCHED_ID_W requesters)
//   sched_idx_w(): index width for a given count, never below 1 bit
// -----------------------------------------------------------------------------
package fpnew_pkg;

   localparam int unsigned SCHED_ID_W    = 4;
   localparam int unsigned SCHED_MAX_REQ = 1 << SCHED_ID_W;

   typedef logic [SCHED_ID_W-1:0] sched_id_t;

   function automatic int unsigned sched_idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fpnew_sched_id_fifo.sv
// -----------------------------------------------------------------------------
// fpnew_sched_id_fifo
// In-order FIFO of requester IDs for ops issued to the shared unit.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : drop all entries (pointers and count to 0)
//   push_i/data_i : append an ID (accepted when not full, or full with pop)
//   pop_i         : remove head (ignored when empty)
//   full_o/empty_o: occupancy flags
//   head_o        : ID at the head (oldest in-flight op)
//   count_o       : number of stored IDs
// -----------------------------------------------------------------------------
module fpnew_sched_id_fifo
   import fpnew_pkg::*;
#(
   parameter  int unsigned Depth = 4,
   localparam int unsigned CntW  = $clog2(Depth + 1)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            clr_i,
   input  logic            push_i,
   input  sched_id_t       data_i,
   input  logic            pop_i,
   output logic            full_o,
   output logic            empty_o,
   output sched_id_t       head_o,
   output logic [CntW-1:0] count_o
);

   localparam int unsigned     PtrW    = sched_idx_w(Depth);
   localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

   sched_id_t       mem_q [Depth];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            push_eff, pop_eff;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == LastPtr) ? '0 : p + PtrW'(1);
   endfunction

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // A push at full is legal only together with a pop: the head slot is read
   // out this cycle and overwritten at the edge.
   assign push_eff = push_i & (~full_o | pop_i);
   assign pop_eff  = pop_i & ~empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_eff) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop_eff)  rd_ptr_d = ptr_inc(rd_ptr_q);
         case ({push_eff, pop_eff})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset: entries are only read while count is nonzero.
   always_ff @(posedge clk_i) begin
      if (push_eff && !clr_i) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/fpnew_opgroup_sched.sv
// -----------------------------------------------------------------------------
// fpnew_opgroup_sched
// Shares one in-order opgroup unit among NumReq requesters. Issue is
// combinational (zero latency); the requester index of each issued op is
// queued so that results coming back in order are routed to their owner.
//
// Configuration macro: FPNEW_SCHED_FAIR_EN
//   defined   : round-robin arbitration, pointer moves past each winner
//   undefined : fixed priority, lowest index wins
//
// Ports:
//   clk_i, rst_ni                         : clock, async active-low reset
//   req_valid_i/req_ready_o/req_i         : per-requester issue handshake
//   unit_valid_o/unit_ready_i/unit_req_o  : issue to the shared unit
//   unit_resp_valid_i/_ready_o/unit_resp_i: result from the unit
//   resp_valid_o/resp_ready_i/resp_o      : per-requester result (data broadcast)
//   flush_i/flush_o                       : abort all in-flight ops
//   busy_o, inflight_o                    : ops outstanding / their count
//   err_o                                 : sticky "result with nothing in flight"
// -----------------------------------------------------------------------------
module fpnew_opgroup_sched
   import fpnew_pkg::*;
#(
   parameter  int unsigned NumReq      = 2,
   parameter  int unsigned MaxInflight = 4,
   parameter  type         ReqType     = logic,
   parameter  type         RespType    = logic,
   localparam int unsigned CntW        = $clog2(MaxInflight + 1)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [NumReq-1:0] req_valid_i,
   output logic [NumReq-1:0] req_ready_o,
   input  ReqType            req_i [NumReq],
   output logic              unit_valid_o,
   input  logic              unit_ready_i,
   output ReqType            unit_req_o,
   input  logic              unit_resp_valid_i,
   output logic              unit_resp_ready_o,
   input  RespType           unit_resp_i,
   output logic [NumReq-1:0] resp_valid_o,
   input  logic [NumReq-1:0] resp_ready_i,
   output RespType           resp_o,
   input  logic              flush_i,
   output logic              flush_o,
   output logic              busy_o,
   output logic [CntW-1:0]   inflight_o,
   output logic              err_o
);

   localparam int unsigned IdxW = sched_idx_w(NumReq);

   logic [IdxW-1:0]   arb_winner;
   logic [IdxW-1:0]   winner;
   logic [IdxW-1:0]   hold_idx_q, hold_idx_d;
   logic              hold_q, hold_d;
   logic              err_q, err_d;
   logic              any_valid;
   logic              can_issue, issue_hs, retire_hs;
   logic              fifo_full, fifo_empty;
   sched_id_t         head_id;
   logic [CntW-1:0]   count;
   logic [NumReq-1:0] head_oh;

   assign any_valid = |req_valid_i;

   // ---------------------------------------------------------------- arbiter
`ifdef FPNEW_SCHED_FAIR_EN
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);

   logic [IdxW-1:0]   ptr_q, ptr_d;
   logic [NumReq-1:0] rot_valid;
   logic [IdxW-1:0]   rr_off;
   logic              rr_found;

   // Rotate the request vector so bit 0 is the pointer position, take the
   // first set bit, then map the offset back to an absolute index.
   always_comb begin
      rot_valid = NumReq'({req_valid_i, req_valid_i} >> ptr_q);
      rr_off    = '0;
      rr_found  = 1'b0;
      for (int unsigned k = 0; k < NumReq; k++) begin
         if (!rr_found && rot_valid[k]) begin
            rr_found = 1'b1;
            rr_off   = IdxW'(k);
         end
      end
      if (ptr_q > (LastIdx - rr_off)) begin
         arb_winner = ptr_q - (LastIdx - rr_off) - IdxW'(1);
      end else begin
         arb_winner = ptr_q + rr_off;
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (issue_hs) ptr_d = (winner == LastIdx) ? '0 : winner + IdxW'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ptr_q <= '0;
      else         ptr_q <= ptr_d;
   end
`else
   logic fp_found;

   always_comb begin
      arb_winner = '0;
      fp_found   = 1'b0;
      for (int unsigned k = 0; k < NumReq; k++) begin
         if (!fp_found && req_valid_i[k]) begin
            fp_found   = 1'b1;
            arb_winner = IdxW'(k);
         end
      end
   end
`endif

   // A requester left waiting (valid, not accepted) keeps the grant until it
   // is accepted or withdraws, so its request is never overtaken mid-wait.
   always_comb begin
      winner = arb_winner;
      if (hold_q && req_valid_i[hold_idx_q]) winner = hold_idx_q;
   end

   assign hold_d     = any_valid & ~issue_hs;
   assign hold_idx_d = winner;

   // ---------------------------------------------------------------- issue
   assign retire_hs    = unit_resp_valid_i & unit_resp_ready_o & ~fifo_empty;
   assign can_issue    = ~fifo_full | retire_hs;
   assign unit_valid_o = any_valid & can_issue & ~flush_i;
   assign issue_hs     = unit_valid_o & unit_ready_i;
   assign unit_req_o   = req_i[winner];

   always_comb begin
      req_ready_o = '0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         req_ready_o[i] = issue_hs & (winner == IdxW'(i));
      end
   end

   // ---------------------------------------------------------------- id fifo
   fpnew_sched_id_fifo #(
      .Depth   (MaxInflight)
   ) u_id_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clr_i   (flush_i),
      .push_i  (issue_hs),
      .data_i  (sched_id_t'(winner)),
      .pop_i   (retire_hs),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (head_id),
      .count_o (count)
   );

   // ---------------------------------------------------------------- response
   always_comb begin
      head_oh = '0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         head_oh[i] = (head_id == sched_id_t'(i));
      end
   end

   // A result with nothing in flight is consumed and dropped so the unit
   // cannot stall on it; err_o records the event.
   always_comb begin
      resp_valid_o      = '0;
      unit_resp_ready_o = 1'b0;
      if (!flush_i) begin
         if (fifo_empty) begin
            unit_resp_ready_o = unit_resp_valid_i;
         end else begin
            resp_valid_o      = unit_resp_valid_i ? head_oh : '0;
            unit_resp_ready_o = |(resp_ready_i & head_oh);
         end
      end
   end

   assign err_d = err_q | (unit_resp_valid_i & fifo_empty & ~flush_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hold_q     <= 1'b0;
         hold_idx_q <= '0;
         err_q      <= 1'b0;
      end else begin
         hold_q     <= hold_d;
         hold_idx_q <= hold_idx_d;
         err_q      <= err_d;
      end
   end

   assign resp_o     = unit_resp_i;
   assign flush_o    = flush_i;
   assign busy_o     = (count != '0);
   assign inflight_o = count;
   assign err_o      = err_q;

endmodule

// File: tb/tb_fpnew_opgroup_sched.sv
module tb_fpnew_opgroup_sched;

   localparam int NREQ = 2;
   localparam int MAXI = 4;
   localparam int CW   = $clog2(MAXI + 1);

   typedef logic [7:0] req_t;
   typedef logic [7:0] rsp_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NREQ-1:0] req_valid, req_ready, resp_valid, resp_ready;
   req_t            req [NREQ];
   req_t            unit_req;
   logic            unit_valid, unit_ready, unit_resp_valid, unit_resp_ready;
   rsp_t            unit_resp, resp;
   logic            flush_i, flush_o, busy, err;
   logic [CW-1:0]   inflight;

   int              n_chk = 0;
   int              n_bad = 0;
   int              q_iss [$];
   logic [NREQ-1:0] q_rsp [$];
   rsp_t            q_rdat [$];
   int              mon_e;
   logic [NREQ-1:0] mon_oh;
   rsp_t            mon_d;
   logic [NREQ-1:0] drain_oh [4];

   always #5 clk = ~clk;

   fpnew_opgroup_sched #(
      .NumReq            (NREQ),
      .MaxInflight       (MAXI),
      .ReqType           (req_t),
      .RespType          (rsp_t)
   ) dut (
      .clk_i             (clk),
      .rst_ni            (rst_n),
      .req_valid_i       (req_valid),
      .req_ready_o       (req_ready),
      .req_i             (req),
      .unit_valid_o      (unit_valid),
      .unit_ready_i      (unit_ready),
      .unit_req_o        (unit_req),
      .unit_resp_valid_i (unit_resp_valid),
      .unit_resp_ready_o (unit_resp_ready),
      .unit_resp_i       (unit_resp),
      .resp_valid_o      (resp_valid),
      .resp_ready_i      (resp_ready),
      .resp_o            (resp),
      .flush_i           (flush_i),
      .flush_o           (flush_o),
      .busy_o            (busy),
      .inflight_o        (inflight),
      .err_o             (err)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: compare every issue and response handshake against the
   // expectations queued by the stimulus.
   always @(negedge clk) begin
      if (rst_n) begin
         if (unit_valid && unit_ready) begin
            if (q_iss.size() == 0) begin
               check_eq("iss_extra", 32'(req_ready), 32'(0));
            end else begin
               mon_e = q_iss.pop_front();
               check_eq("iss_data", 32'(unit_req), 32'h0A0 + 32'(mon_e));
               check_eq("iss_rdy", 32'(req_ready), 32'(1) << mon_e);
            end
         end
         if ((resp_valid & resp_ready) != '0) begin
            if (q_rsp.size() == 0 || q_rdat.size() == 0) begin
               check_eq("rsp_extra", 32'(resp_valid), 32'(0));
            end else begin
               mon_oh = q_rsp.pop_front();
               mon_d  = q_rdat.pop_front();
               check_eq("rsp_route", 32'(resp_valid), 32'(mon_oh));
               check_eq("rsp_data", 32'(resp), 32'(mon_d));
               check_eq("rsp_urdy", 32'(unit_resp_ready), 32'(1));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef FPNEW_SCHED_FAIR_EN
      drain_oh = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
      drain_oh = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
      rst_n = 1'b0; req_valid = '0; req[0] = 8'hA0; req[1] = 8'hA1;
      unit_ready = 1'b0; unit_resp_valid = 1'b0; unit_resp = '0;
      resp_ready = '0; flush_i = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_uvalid", 32'(unit_valid), 32'(0));
      check_eq("rst_rdy", 32'(req_ready), 32'(0));
      check_eq("rst_rvalid", 32'(resp_valid), 32'(0));
      check_eq("rst_urrdy", 32'(unit_resp_ready), 32'(0));
      check_eq("rst_busy", 32'(busy), 32'(0));
      check_eq("rst_infl", 32'(inflight), 32'(0));
      check_eq("rst_err", 32'(err), 32'(0));
      check_eq("rst_flush", 32'(flush_o), 32'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick();

      // Both requesters valid for four cycles: arbitration order.
      unit_ready = 1'b1; req_valid = 2'b11;
`ifdef FPNEW_SCHED_FAIR_EN
      q_iss = '{0, 1, 0, 1};
`else
      q_iss = '{0, 0, 0, 0};
`endif
      repeat (4) tick();
      req_valid = '0;
      check_eq("full_infl", 32'(inflight), 32'(4));
      check_eq("full_busy", 32'(busy), 32'(1));

      // Full with no retire: request refused.
      req_valid = 2'b01;
      @(negedge clk);
      check_eq("full_rdy", 32'(req_ready), 32'(0));
      check_eq("full_uvalid", 32'(unit_valid), 32'(0));
      tick();
      check_eq("full_hold_infl", 32'(inflight), 32'(4));

      // Full with same-cycle retire: issue accepted, count unchanged.
      unit_resp_valid = 1'b1; resp_ready = 2'b11; unit_resp = 8'h55;
      q_rsp.push_back(2'b01); q_rdat.push_back(8'h55); q_iss.push_back(0);
      tick();
      req_valid = '0;
      check_eq("swap_infl", 32'(inflight), 32'(4));

      // Drain the four outstanding ops.
      for (int k = 0; k < 4; k++) begin
         unit_resp = rsp_t'(8'h60 + k);
         q_rsp.push_back(drain_oh[k]); q_rdat.push_back(rsp_t'(8'h60 + k));
         tick();
      end
      unit_resp_valid = 1'b0;
      check_eq("drain_infl", 32'(inflight), 32'(0));
      check_eq("drain_busy", 32'(busy), 32'(0));

      // Issues from 1,0,1 then responses routed 10,01,10.
      q_iss.push_back(1); req_valid = 2'b10; tick();
      q_iss.push_back(0); req_valid = 2'b01; tick();
      q_iss.push_back(1); req_valid = 2'b10; tick();
      req_valid = '0;
      check_eq("route_infl", 32'(inflight), 32'(3));
      unit_resp_valid = 1'b1; unit_resp = 8'h71; resp_ready = 2'b01;
      @(negedge clk);
      check_eq("bp_rvalid", 32'(resp_valid), 32'(2'b10));
      check_eq("bp_urrdy", 32'(unit_resp_ready), 32'(0));
      tick();
      check_eq("bp_infl", 32'(inflight), 32'(3));
      resp_ready = 2'b11;
      q_rsp.push_back(2'b10); q_rdat.push_back(8'h71); tick();
      unit_resp = 8'h72; q_rsp.push_back(2'b01); q_rdat.push_back(8'h72); tick();
      unit_resp = 8'h73; q_rsp.push_back(2'b10); q_rdat.push_back(8'h73); tick();
      unit_resp_valid = 1'b0;
      check_eq("route_done_infl", 32'(inflight), 32'(0));

      // Grant held on a waiting requester when a higher-priority one arrives.
      unit_ready = 1'b0; req_valid = 2'b10; tick();
      req_valid = 2'b11;
      @(negedge clk);
      check_eq("hold_req", 32'(unit_req), 32'(8'hA1));
      tick();
      unit_ready = 1'b1; q_iss.push_back(1); tick();
      req_valid = 2'b01; q_iss.push_back(0); q_iss.push_back(0);
      repeat (2) tick();
      req_valid = '0;
      check_eq("pre_flush_infl", 32'(inflight), 32'(3));

      // Flush: issue and responses suppressed, bookkeeping cleared.
      flush_i = 1'b1; req_valid = 2'b01; unit_resp_valid = 1'b1; unit_resp = 8'h99;
      @(negedge clk);
      check_eq("fl_flush_o", 32'(flush_o), 32'(1));
      check_eq("fl_uvalid", 32'(unit_valid), 32'(0));
      check_eq("fl_rvalid", 32'(resp_valid), 32'(0));
      check_eq("fl_urrdy", 32'(unit_resp_ready), 32'(0));
      tick();
      flush_i = 1'b0; req_valid = '0; unit_resp_valid = 1'b0;
      check_eq("fl_infl", 32'(inflight), 32'(0));
      check_eq("fl_busy", 32'(busy), 32'(0));
      check_eq("fl_err", 32'(err), 32'(0));
      check_eq("fl_flush_off", 32'(flush_o), 32'(0));

      // Response with nothing in flight: dropped, sticky error.
      unit_resp_valid = 1'b1; unit_resp = 8'hEE;
      @(negedge clk);
      check_eq("orph_rvalid", 32'(resp_valid), 32'(0));
      check_eq("orph_urrdy", 32'(unit_resp_ready), 32'(1));
      tick();
      unit_resp_valid = 1'b0;
      check_eq("orph_err", 32'(err), 32'(1));
      tick();
      check_eq("orph_err_sticky", 32'(err), 32'(1));

      // Normal traffic still works afterwards; error stays set.
      q_iss.push_back(1); req_valid = 2'b10; tick();
      req_valid = '0;
      unit_resp_valid = 1'b1; unit_resp = 8'h42;
      q_rsp.push_back(2'b10); q_rdat.push_back(8'h42); tick();
      unit_resp_valid = 1'b0;
      check_eq("post_err", 32'(err), 32'(1));
      check_eq("post_infl", 32'(inflight), 32'(0));

      tick();
      check_eq("left_iss", 32'(q_iss.size()), 32'(0));
      check_eq("left_rsp", 32'(q_rsp.size()), 32'(0));
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
